// File: rtl/if_fetch_stage_if.sv
// Instruction SRAM port: the fetch stage is master; the memory answers one cycle later.
interface if_fetch_stage_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, addr, wdata, input rdata);
  modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address, drives the inst SRAM
// and presents {Inst, PC, PC+4, fault} to IF/ID, with a nop bubble whenever fetch is not valid.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  input  logic                     exc_flush,
  input  logic [31:0]              exc_pc,
  if_fetch_stage_if.master         sram,
  output logic [31:0]              Inst_out,
  output logic [31:0]              PC_out,
  output logic [31:0]              PC4_out,
  output logic                     IF_addr_fault_out
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [31:0] pc_reg, next_pc, redir_pc, redir_pc_d, pc_plus4;
  logic [0:0]  state;
  logic        redir_pend, redir_pend_d;
  logic        fault;

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    next_pc      = pc_plus4;
    redir_pend_d = redir_pend;
    redir_pc_d   = redir_pc;
    if (exc_flush) begin
      next_pc      = exc_pc;
      redir_pend_d = 1'b0;
    end else if (state == BOOT) begin
      next_pc = RESET_PC;
    end else if (stall) begin
      // Park a redirect that ID resolves while frozen; a re-evaluation overwrites it.
      next_pc = pc_reg;
      if (branch_taken) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = branch_target;
      end
    end else if (redir_pend) begin
      next_pc      = redir_pc;
      redir_pend_d = 1'b0;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      state      <= BOOT;
      redir_pend <= 1'b0;
      redir_pc   <= 32'h0;
    end else begin
      pc_reg     <= next_pc;
      state      <= RUN;
      redir_pend <= redir_pend_d;
      redir_pc   <= redir_pc_d;
    end
  end

  // Misaligned addresses never reach the SRAM; the fault travels down the pipe instead.
  assign sram.en    = rst_n & (next_pc[1:0] == 2'b00);
  assign sram.wen   = 4'b0000;
  assign sram.addr  = next_pc;
  assign sram.wdata = 32'h0;

  assign fault             = (state == RUN) & (pc_reg[1:0] != 2'b00);
  assign PC_out            = pc_reg;
  assign PC4_out           = pc_plus4;
  assign IF_addr_fault_out = fault;
  assign Inst_out          = ((state == BOOT) || exc_flush || fault) ? 32'h0 : sram.rdata;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a 1-cycle-latency SRAM model.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, exc_flush;
  logic [31:0] branch_target, exc_pc;
  logic [31:0] Inst_out, PC_out, PC4_out;
  logic        IF_addr_fault_out;
  int          nvec = 0;
  int          nerr = 0;

  if_fetch_stage_if sram();

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .exc_flush(exc_flush), .exc_pc(exc_pc),
    .sram(sram), .Inst_out(Inst_out), .PC_out(PC_out), .PC4_out(PC4_out),
    .IF_addr_fault_out(IF_addr_fault_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous SRAM: data for last cycle's address; garbage when not enabled.
  always @(posedge clk) begin
    if (sram.en) sram.rdata <= mem(sram.addr);
    else         sram.rdata <= 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; branch_taken = 0; exc_flush = 0;
    branch_target = 32'h0; exc_pc = 32'h0;
    tick(); tick(); #1;
    nvec++; if (sram.en !== 1'b0) begin nerr++; $display("FAIL rst_en got %h want 0", sram.en); end
    nvec++; if (Inst_out !== 32'h0) begin nerr++; $display("FAIL rst_inst got %h want 0", Inst_out); end
    nvec++; if (IF_addr_fault_out !== 1'b0) begin nerr++; $display("FAIL rst_fault got %h want 0", IF_addr_fault_out); end
    nvec++; if (PC_out !== 32'hBFC0_0000) begin nerr++; $display("FAIL rst_pc got %h want BFC00000", PC_out); end
    nvec++; if (PC4_out !== 32'hBFC0_0004) begin nerr++; $display("FAIL rst_pc4 got %h want BFC00004", PC4_out); end
    rst_n = 1'b1; #1;
    nvec++; if (sram.en !== 1'b1) begin nerr++; $display("FAIL t0_en got %h want 1", sram.en); end
    nvec++; if (sram.addr !== 32'hBFC0_0000) begin nerr++; $display("FAIL t0_addr got %h want BFC00000", sram.addr); end
    nvec++; if (Inst_out !== 32'h0) begin nerr++; $display("FAIL t0_inst got %h want 0", Inst_out); end
    nvec++; if (sram.wen !== 4'h0 || sram.wdata !== 32'h0) begin nerr++; $display("FAIL t0_wr got %h/%h want 0/0", sram.wen, sram.wdata); end
    tick(); #1;
    nvec++; if (PC_out !== 32'hBFC0_0000) begin nerr++; $display("FAIL t1_pc got %h want BFC00000", PC_out); end
    nvec++; if (Inst_out !== mem(32'hBFC0_0000)) begin nerr++; $display("FAIL t1_inst got %h want %h", Inst_out, mem(32'hBFC0_0000)); end
    nvec++; if (sram.addr !== 32'hBFC0_0004) begin nerr++; $display("FAIL t1_addr got %h want BFC00004", sram.addr); end
  endtask

  task automatic test_seq();
    logic [31:0] exp;
    for (int i = 1; i < 3; i++) begin
      exp = 32'hBFC0_0000 + 32'(4 * i);
      tick(); #1;
      nvec++; if (PC_out !== exp) begin nerr++; $display("FAIL seq_pc got %h want %h", PC_out, exp); end
      nvec++; if (PC4_out !== exp + 32'd4) begin nerr++; $display("FAIL seq_pc4 got %h want %h", PC4_out, exp + 32'd4); end
      nvec++; if (Inst_out !== mem(exp)) begin nerr++; $display("FAIL seq_inst got %h want %h", Inst_out, mem(exp)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; #1;
    nvec++; if (sram.addr !== 32'hBFC0_0008) begin nerr++; $display("FAIL stall_addr0 got %h want BFC00008", sram.addr); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      nvec++; if (PC_out !== 32'hBFC0_0008) begin nerr++; $display("FAIL stall_pc got %h want BFC00008", PC_out); end
      nvec++; if (sram.addr !== 32'hBFC0_0008) begin nerr++; $display("FAIL stall_addr got %h want BFC00008", sram.addr); end
      nvec++; if (Inst_out !== mem(32'hBFC0_0008)) begin nerr++; $display("FAIL stall_inst got %h want %h", Inst_out, mem(32'hBFC0_0008)); end
    end
    stall = 1'b0; #1;
    nvec++; if (sram.addr !== 32'hBFC0_000C) begin nerr++; $display("FAIL unstall_addr got %h want BFC0000C", sram.addr); end
    tick(); #1;
    nvec++; if (PC_out !== 32'hBFC0_000C) begin nerr++; $display("FAIL unstall_pc got %h want BFC0000C", PC_out); end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0100; #1;
    nvec++; if (sram.addr !== 32'hBFC0_000C) begin nerr++; $display("FAIL bst_addr0 got %h want BFC0000C", sram.addr); end
    tick(); branch_taken = 1'b0; branch_target = 32'h0; #1;
    nvec++; if (sram.addr !== 32'hBFC0_000C) begin nerr++; $display("FAIL bst_hold got %h want BFC0000C", sram.addr); end
    tick(); stall = 1'b0; #1;
    nvec++; if (sram.addr !== 32'hBFC0_0100) begin nerr++; $display("FAIL bst_redir got %h want BFC00100", sram.addr); end
    tick(); #1;
    nvec++; if (PC_out !== 32'hBFC0_0100) begin nerr++; $display("FAIL bst_pc got %h want BFC00100", PC_out); end
    nvec++; if (Inst_out !== mem(32'hBFC0_0100)) begin nerr++; $display("FAIL bst_inst got %h want %h", Inst_out, mem(32'hBFC0_0100)); end
  endtask

  task automatic test_delay_slot();
    branch_taken = 1'b1; branch_target = 32'hBFC0_0200; #1;
    nvec++; if (Inst_out !== mem(32'hBFC0_0100)) begin nerr++; $display("FAIL slot_inst got %h want %h", Inst_out, mem(32'hBFC0_0100)); end
    nvec++; if (sram.addr !== 32'hBFC0_0200) begin nerr++; $display("FAIL slot_addr got %h want BFC00200", sram.addr); end
    tick(); branch_taken = 1'b0; #1;
    nvec++; if (PC_out !== 32'hBFC0_0200) begin nerr++; $display("FAIL slot_tgt got %h want BFC00200", PC_out); end
    nvec++; if (Inst_out !== mem(32'hBFC0_0200)) begin nerr++; $display("FAIL slot_tinst got %h want %h", Inst_out, mem(32'hBFC0_0200)); end
  endtask

  task automatic test_exc();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0300;
    tick(); branch_taken = 1'b0; exc_flush = 1'b1; exc_pc = 32'hBFC0_0380; #1;
    nvec++; if (Inst_out !== 32'h0) begin nerr++; $display("FAIL exc_kill got %h want 0", Inst_out); end
    nvec++; if (sram.addr !== 32'hBFC0_0380) begin nerr++; $display("FAIL exc_addr got %h want BFC00380", sram.addr); end
    tick(); exc_flush = 1'b0; stall = 1'b0; #1;
    nvec++; if (PC_out !== 32'hBFC0_0380) begin nerr++; $display("FAIL exc_pc got %h want BFC00380", PC_out); end
    nvec++; if (sram.addr !== 32'hBFC0_0384) begin nerr++; $display("FAIL exc_noredir got %h want BFC00384", sram.addr); end
    tick(); #1;
    nvec++; if (Inst_out !== mem(32'hBFC0_0384)) begin nerr++; $display("FAIL exc_next got %h want %h", Inst_out, mem(32'hBFC0_0384)); end
  endtask

  task automatic test_redir_overwrite();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0500;
    tick(); branch_target = 32'hBFC0_0600;
    tick(); stall = 1'b0; branch_taken = 1'b0; #1;
    nvec++; if (sram.addr !== 32'hBFC0_0600) begin nerr++; $display("FAIL ovw_addr got %h want BFC00600", sram.addr); end
    tick(); #1;
    nvec++; if (PC_out !== 32'hBFC0_0600) begin nerr++; $display("FAIL ovw_pc got %h want BFC00600", PC_out); end
  endtask

  task automatic test_fault();
    branch_taken = 1'b1; branch_target = 32'hBFC0_0102; #1;
    nvec++; if (sram.en !== 1'b0) begin nerr++; $display("FAIL flt_en got %h want 0", sram.en); end
    nvec++; if (sram.addr !== 32'hBFC0_0102) begin nerr++; $display("FAIL flt_addr got %h want BFC00102", sram.addr); end
    tick(); branch_taken = 1'b0; #1;
    nvec++; if (PC_out !== 32'hBFC0_0102) begin nerr++; $display("FAIL flt_pc got %h want BFC00102", PC_out); end
    nvec++; if (IF_addr_fault_out !== 1'b1) begin nerr++; $display("FAIL flt_flag got %h want 1", IF_addr_fault_out); end
    nvec++; if (Inst_out !== 32'h0) begin nerr++; $display("FAIL flt_inst got %h want 0", Inst_out); end
    exc_flush = 1'b1; exc_pc = 32'hBFC0_0380; #1;
    nvec++; if (sram.en !== 1'b1) begin nerr++; $display("FAIL flt_exc_en got %h want 1", sram.en); end
    tick(); exc_flush = 1'b0; #1;
    nvec++; if (IF_addr_fault_out !== 1'b0) begin nerr++; $display("FAIL flt_clr got %h want 0", IF_addr_fault_out); end
    nvec++; if (Inst_out !== mem(32'hBFC0_0380)) begin nerr++; $display("FAIL flt_inst2 got %h want %h", Inst_out, mem(32'hBFC0_0380)); end
  endtask

  task automatic test_wrap();
    exc_flush = 1'b1; exc_pc = 32'hFFFF_FFFC;
    tick(); exc_flush = 1'b0; #1;
    nvec++; if (PC4_out !== 32'h0) begin nerr++; $display("FAIL wrap_pc4 got %h want 0", PC4_out); end
    nvec++; if (sram.addr !== 32'h0) begin nerr++; $display("FAIL wrap_addr got %h want 0", sram.addr); end
    tick(); #1;
    nvec++; if (PC_out !== 32'h0) begin nerr++; $display("FAIL wrap_pc got %h want 0", PC_out); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hBFC0_0700;
    tick(); branch_taken = 1'b0; rst_n = 1'b0; #1;
    nvec++; if (PC_out !== 32'hBFC0_0000) begin nerr++; $display("FAIL arst_pc got %h want BFC00000", PC_out); end
    nvec++; if (sram.en !== 1'b0) begin nerr++; $display("FAIL arst_en got %h want 0", sram.en); end
    tick(); rst_n = 1'b1; #1;
    nvec++; if (sram.addr !== 32'hBFC0_0000) begin nerr++; $display("FAIL boot_addr got %h want BFC00000", sram.addr); end
    tick(); #1;
    nvec++; if (PC_out !== 32'hBFC0_0000) begin nerr++; $display("FAIL boot_pc got %h want BFC00000", PC_out); end
    nvec++; if (Inst_out !== mem(32'hBFC0_0000)) begin nerr++; $display("FAIL boot_inst got %h want %h", Inst_out, mem(32'hBFC0_0000)); end
    stall = 1'b0; #1;
    nvec++; if (sram.addr !== 32'hBFC0_0004) begin nerr++; $display("FAIL boot_noredir got %h want BFC00004", sram.addr); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_branch_stall();
    test_delay_slot();
    test_exc();
    test_redir_overwrite();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
